// File: rtl/bram_ctrl_if.sv
// Command/data bus between the host or sequencer and the BRAM storage controller.
// The master issues one-cycle strobes. The slave returns the read words, ready and template_change.
interface bram_ctrl_if;
    logic         input_write;
    logic         template_write;
    logic         ff_write;
    logic [127:0] write_data_0;
    logic [127:0] write_data_1;
    logic         template_read;
    logic [1:0]   template_bits;
    logic         input_read;
    logic         ff_read;
    logic [127:0] read_data_0;
    logic [127:0] read_data_1;
    logic         template_change;
    logic         ready;

    modport master (
        output input_write, template_write, ff_write, write_data_0, write_data_1,
               template_read, template_bits, input_read, ff_read,
        input  read_data_0, read_data_1, template_change, ready
    );

    modport slave (
        input  input_write, template_write, ff_write, write_data_0, write_data_1,
               template_read, template_bits, input_read, ff_read,
        output read_data_0, read_data_1, template_change, ready
    );
endinterface

// File: rtl/bram_ctrl.sv
// Template store, flip-flop pair store and input-vector FIFO behind a serialized strobe/ready handshake.
// Every access goes through a registered BRAM read, so reads take a fixed three cycles.
module bram_ctrl #(
    parameter int INPUT_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    bram_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(INPUT_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(INPUT_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DONE, S_RADDR, S_RWAIT, S_RCAP} state_t;
    typedef enum logic [2:0] {CMD_TW, CMD_FW, CMD_IW, CMD_TR, CMD_FR, CMD_IR} cmd_t;

    state_t             state_reg, state_next;
    cmd_t               cmd_reg, cmd_next;
    logic               any_strobe, accept;
    logic [1:0]         slot_reg, slot_next;
    logic [127:0]       wdata0_reg, wdata1_reg;
    logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic [1:0]         last_tmpl_reg;
    logic [127:0]       rd0_reg, rd1_reg;
    logic               tc_reg;
    logic               fifo_push, fifo_pop;

    logic [127:0] tmpl_mem [4];
    logic [127:0] ff0_mem  [4];
    logic [127:0] ff1_mem  [4];
    logic [127:0] fifo_mem [INPUT_DEPTH];
    logic [127:0] tmpl_q, ff0_q, ff1_q, fifo_q;

    // Fixed-priority decode. Only the winning strobe is turned into a command.
    always_comb begin
        cmd_next   = CMD_TW;
        slot_next  = bus.write_data_0[127:126];
        any_strobe = 1'b1;
        if (bus.template_write) begin
            cmd_next = CMD_TW;
        end else if (bus.ff_write) begin
            cmd_next  = CMD_FW;
            slot_next = bus.write_data_1[127:126];
        end else if (bus.input_write) begin
            cmd_next = CMD_IW;
        end else if (bus.template_read) begin
            cmd_next  = CMD_TR;
            slot_next = bus.template_bits;
        end else if (bus.ff_read) begin
            cmd_next  = CMD_FR;
            slot_next = bus.template_bits;
        end else if (bus.input_read) begin
            cmd_next = CMD_IR;
        end else begin
            any_strobe = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (any_strobe) begin
                    accept     = 1'b1;
                    state_next = (cmd_next inside {CMD_TW, CMD_FW, CMD_IW}) ? S_WRITE : S_RADDR;
                end
            end
            S_WRITE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_RADDR: state_next = S_RWAIT;
            S_RWAIT: state_next = S_RCAP;
            S_RCAP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // A full FIFO still completes the write handshake. The word is simply not stored.
    assign fifo_push = (state_reg == S_WRITE) && (cmd_reg == CMD_IW) && (count_reg != FULL_COUNT);
    assign fifo_pop  = (state_reg == S_RCAP) && (cmd_reg == CMD_IR) && (count_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg       <= CMD_TW;
            slot_reg      <= '0;
            wdata0_reg    <= '0;
            wdata1_reg    <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            last_tmpl_reg <= '0;
            rd0_reg       <= '0;
            rd1_reg       <= '0;
            tc_reg        <= 1'b0;
        end else begin
            if (accept) begin
                cmd_reg    <= cmd_next;
                slot_reg   <= slot_next;
                wdata0_reg <= bus.write_data_0;
                wdata1_reg <= bus.write_data_1;
                tc_reg     <= 1'b0;
            end
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                count_reg  <= count_reg + 1'b1;
            end
            if (state_reg == S_RCAP) begin
                case (cmd_reg)
                    CMD_TR: rd0_reg <= tmpl_q;
                    CMD_FR: begin
                        rd0_reg <= ff0_q;
                        rd1_reg <= ff1_q;
                    end
                    default: ;
                endcase
            end
            if (fifo_pop) begin
                rd0_reg       <= fifo_q;
                tc_reg        <= (fifo_q[127:126] != last_tmpl_reg);
                last_tmpl_reg <= fifo_q[127:126];
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                count_reg     <= count_reg - 1'b1;
            end
        end
    end

    // The memory arrays have no reset. Each is read into a register every cycle.
    always_ff @(posedge clk) begin
        if (state_reg == S_WRITE && cmd_reg == CMD_TW) tmpl_mem[slot_reg] <= wdata0_reg;
        if (state_reg == S_WRITE && cmd_reg == CMD_FW) begin
            ff0_mem[slot_reg] <= wdata0_reg;
            ff1_mem[slot_reg] <= wdata1_reg;
        end
        if (fifo_push) fifo_mem[wr_ptr_reg] <= wdata0_reg;
        tmpl_q <= tmpl_mem[slot_reg];
        ff0_q  <= ff0_mem[slot_reg];
        ff1_q  <= ff1_mem[slot_reg];
        fifo_q <= fifo_mem[rd_ptr_reg];
    end

    assign bus.ready           = (state_reg == S_IDLE);
    assign bus.read_data_0     = rd0_reg;
    assign bus.read_data_1     = rd1_reg;
    assign bus.template_change = tc_reg;
endmodule

// File: tb/tb_bram_ctrl.sv
// Directed scoreboard bench for bram_ctrl: a reference model predicts outputs and handshake length per command.
// Expected values are queued at issue and checked when ready returns.
module tb_bram_ctrl;
    localparam int DEPTH = 16;
    localparam logic [127:0] WA = 128'h0123FEEDDEADBEEF0123FEEDDEADBEEF;
    localparam logic [127:0] WC = 128'hC123FEEDDEADBEEF0123FEEDDEADBEEF;
    localparam logic [127:0] WF = 128'hFEEDDEADBEEFEEEEDDDDCCCCBBBBAAAA;
    localparam logic [127:0] WB = 128'h4444333322221111AAAABBBBCCCCDDDD;
    localparam logic [127:0] WP = 128'h0000000000000000FFFFFFFF12345678;
    localparam logic [5:0] S_TW = 6'b100000, S_FW = 6'b010000, S_IW = 6'b001000,
                           S_TR = 6'b000100, S_FR = 6'b000010, S_IR = 6'b000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_ctrl_if bus ();
    bram_ctrl #(.INPUT_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [127:0] d0;
        logic [127:0] d1;
        logic         tc;
        int           low;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] tmpl_m [4];
    logic [127:0] ff0_m [4];
    logic [127:0] ff1_m [4];
    logic [127:0] fifo_m[$];
    logic [127:0] m_d0 = '0, m_d1 = '0;
    logic         m_tc = 1'b0;
    logic [1:0]   m_last = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void model_apply(input logic [5:0] stb, input logic [127:0] d0,
                                        input logic [127:0] d1, input logic [1:0] bits);
        exp_t e;
        logic [127:0] w;
        m_tc  = 1'b0;
        e.low = (stb[5] | stb[4] | stb[3]) ? 2 : 3;
        if (stb[5]) tmpl_m[d0[127:126]] = d0;
        else if (stb[4]) begin
            ff0_m[d1[127:126]] = d0;
            ff1_m[d1[127:126]] = d1;
        end else if (stb[3]) begin
            if (fifo_m.size() < DEPTH) fifo_m.push_back(d0);
        end else if (stb[2]) m_d0 = tmpl_m[bits];
        else if (stb[1]) begin
            m_d0 = ff0_m[bits];
            m_d1 = ff1_m[bits];
        end else if (fifo_m.size() > 0) begin
            w      = fifo_m.pop_front();
            m_tc   = (w[127:126] != m_last);
            m_last = w[127:126];
            m_d0   = w;
        end
        e.d0 = m_d0;
        e.d1 = m_d1;
        e.tc = m_tc;
        sb.push_back(e);
    endfunction

    // Issues one command. If poke is set, it also pulses template_write while busy; that pulse must be ignored.
    task automatic cmd(input string tag, input logic [5:0] stb, input logic [127:0] d0,
                       input logic [127:0] d1, input logic [1:0] bits, input bit poke);
        exp_t e;
        int low;
        model_apply(stb, d0, d1, bits);
        @(negedge clk);
        {bus.template_write, bus.ff_write, bus.input_write,
         bus.template_read, bus.ff_read, bus.input_read} = stb;
        bus.write_data_0  = d0;
        bus.write_data_1  = d1;
        bus.template_bits = bits;
        @(negedge clk);
        {bus.template_write, bus.ff_write, bus.input_write,
         bus.template_read, bus.ff_read, bus.input_read} = '0;
        bus.write_data_0  = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.write_data_1  = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.template_bits = ~bits;
        low = 0;
        while (bus.ready !== 1'b1 && low < 20) begin
            if (poke && low == 0) begin
                bus.template_write = 1'b1;
                bus.write_data_0   = WP;
            end else begin
                bus.template_write = 1'b0;
            end
            low++;
            @(negedge clk);
        end
        bus.template_write = 1'b0;
        e = sb.pop_front();
        chk({tag, "/ready_low"}, 128'(low), 128'(e.low));
        chk({tag, "/rd0"}, bus.read_data_0, e.d0);
        chk({tag, "/rd1"}, bus.read_data_1, e.d1);
        chk({tag, "/tc"}, 128'(bus.template_change), 128'(e.tc));
        $display("txn %-14s stb=%b low=%0d rd0=%h tc=%b", tag, stb, low, bus.read_data_0,
                 bus.template_change);
    endtask

    initial begin
        logic [127:0] w;
        {bus.template_write, bus.ff_write, bus.input_write,
         bus.template_read, bus.ff_read, bus.input_read} = '0;
        bus.write_data_0  = '0;
        bus.write_data_1  = '0;
        bus.template_bits = '0;
        repeat (3) @(negedge clk);
        chk("reset/ready", 128'(bus.ready), 128'(1));
        chk("reset/rd0", bus.read_data_0, '0);
        chk("reset/rd1", bus.read_data_1, '0);
        chk("reset/tc", 128'(bus.template_change), 128'(0));
        rst_n = 1'b1;

        cmd("tw_slot0", S_TW, WA, '0, 2'd0, 0);
        cmd("tr_slot0", S_TR, '0, '0, 2'd0, 0);
        cmd("tw_slot3", S_TW, WC, '0, 2'd0, 0);
        cmd("tr_slot3", S_TR, '0, '0, 2'd3, 0);
        cmd("tr_slot0b", S_TR, '0, '0, 2'd0, 0);
        cmd("fw_slot3", S_FW, WA, WC, 2'd0, 0);
        cmd("fr_slot3", S_FR, '0, '0, 2'd3, 0);
        cmd("iw_a", S_IW, WA, '0, 2'd0, 0);
        cmd("iw_f", S_IW, WF, '0, 2'd0, 0);
        cmd("ir_a", S_IR, '0, '0, 2'd0, 0);
        cmd("ir_f", S_IR, '0, '0, 2'd0, 0);
        cmd("tw_plus_ir", S_TW | S_IR, WB, '0, 2'd0, 0);
        cmd("tr_slot1", S_TR, '0, '0, 2'd1, 0);
        cmd("ir_empty", S_IR, '0, '0, 2'd0, 0);
        cmd("tw_busy_poke", S_TW, WC, '0, 2'd0, 1);
        cmd("tr_after_poke", S_TR, '0, '0, 2'd0, 0);

        for (int i = 0; i <= DEPTH; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            cmd($sformatf("fill%0d", i), S_IW, w, '0, 2'd0, 0);
        end
        for (int i = 0; i < DEPTH; i++) cmd($sformatf("drain%0d", i), S_IR, '0, '0, 2'd0, 0);
        cmd("drain_empty", S_IR, '0, '0, 2'd0, 0);
        cmd("fr_before_rst", S_FR, '0, '0, 2'd3, 0);

        // Reset asserted while an ff_read is in flight.
        @(negedge clk);
        bus.ff_read       = 1'b1;
        bus.template_bits = 2'd3;
        @(negedge clk);
        bus.ff_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst/ready", 128'(bus.ready), 128'(1));
        chk("midrst/rd0", bus.read_data_0, '0);
        chk("midrst/rd1", bus.read_data_1, '0);
        chk("midrst/tc", 128'(bus.template_change), 128'(0));
        $display("txn mid_read_reset ready=%b rd0=%h", bus.ready, bus.read_data_0);
        sb.delete();
        fifo_m.delete();
        m_d0 = '0; m_d1 = '0; m_tc = 1'b0; m_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cmd("tr_after_rst", S_TR, '0, '0, 2'd3, 0);
        cmd("ir_after_rst", S_IR, '0, '0, 2'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bram_ctrl.md
Name: bram_ctrl

Overview:
- Block-RAM storage controller for the ASIC tester. Holds three stores:
  - 4 template words of 128 bits.
  - 4 FF (flip-flop) word pairs of 2×128 bits.
  - An input-vector FIFO of 128-bit words.
- Single-cycle command strobes start each access. The READY handshake reports when the access is complete.
- Sits between the host/loader logic and the tester sequencer.

Parameters:
- INPUT_DEPTH, 16: input FIFO depth in 128-bit words; must be a power of 2, minimum 2.

Ports:
- CLK, input, 1: sole clock; everything is rising-edge.
- RST, input, 1: asynchronous, active-low reset.
- INPUT_WRITE, input, 1: strobe; push WRITE_DATA_0 into the input FIFO.
- TEMPLATE_WRITE, input, 1: strobe; write WRITE_DATA_0 into template slot WRITE_DATA_0[127:126].
- FF_WRITE, input, 1: strobe; write the pair {WRITE_DATA_1, WRITE_DATA_0} into FF slot WRITE_DATA_1[127:126].
- WRITE_DATA_0, input, 128: write word 0.
- WRITE_DATA_1, input, 128: write word 1 (FF writes only).
- READ_DATA_0, output, 128: read word 0.
- READ_DATA_1, output, 128: read word 1 (FF reads only).
- TEMPLATE_READ, input, 1: strobe; read template slot TEMPLATE_BITS.
- TEMPLATE_BITS, input, 2: slot select for TEMPLATE_READ and FF_READ.
- INPUT_READ, input, 1: strobe; pop the oldest input FIFO word.
- FF_READ, input, 1: strobe; read FF slot TEMPLATE_BITS.
- TEMPLATE_CHANGE, output, 1: the popped input word selects a different template than the previous popped word.
- READY, output, 1: idle; the last result is valid.

Behaviour:
- Reset (RST=0, async):
  - READY=1; READ_DATA_0, READ_DATA_1, TEMPLATE_CHANGE = 0.
  - FIFO read/write pointers and count = 0; last-template register = 0; FSM in IDLE.
  - RAM contents are not cleared.
  - Reset asserted mid-operation aborts it; any partially completed write is undefined.
- Command acceptance:
  - Sampled on a rising edge only while in IDLE (READY=1).
  - Strobes are one-cycle pulses; all strobes are ignored while busy.
  - Simultaneous strobes: one command only, priority TEMPLATE_WRITE > FF_WRITE > INPUT_WRITE > TEMPLATE_READ > FF_READ > INPUT_READ. Lower-priority strobes are dropped.
- Slot index and data are latched at acceptance, so the inputs may change afterwards.
- FSM states: IDLE → WRITE → DONE → IDLE for writes; IDLE → RADDR → RWAIT → RCAP → IDLE for reads.
- READY timing:
  - READY drops on the edge that accepts the command.
  - Writes: READY low for exactly 2 cycles.
  - Reads: READY low for exactly 3 cycles (address, 1-cycle registered BRAM latency, capture).
  - Read data and TEMPLATE_CHANGE update on the same edge that raises READY.
- Template store: 4×128. Write slot is WRITE_DATA_0[127:126]; read slot is TEMPLATE_BITS. A read returns the stored word on READ_DATA_0.
- FF store: 4×256. Write slot is WRITE_DATA_1[127:126]. FF_READ returns word 0 on READ_DATA_0 and word 1 on READ_DATA_1.
- READ_DATA_1 changes only on FF_READ.
- Input FIFO:
  - First in, first out; pointers wrap modulo INPUT_DEPTH.
  - Write when full: data is dropped, but the normal 2-cycle READY handshake still occurs.
  - Read when empty: READ_DATA_0 is unchanged and TEMPLATE_CHANGE=0, with the normal 3-cycle handshake.
- TEMPLATE_CHANGE:
  - On a successful INPUT_READ: TEMPLATE_CHANGE = (popped[127:126] != last-template register); the register is then loaded with popped[127:126].
  - Cleared on the next command acceptance.
  - Never set by other commands.
- Same-slot write followed by read returns the new data (no read-during-write hazard, because operations are serialized).

Test Plan:
- Reset release, then write template 0x0123FEEDDEADBEEF0123FEEDDEADBEEF; wait READY; TEMPLATE_READ with TEMPLATE_BITS=0 → READ_DATA_0 equals that word; READY low exactly 2 cycles for the write and 3 for the read.
- Write template 0xC123FEEDDEADBEEF0123FEEDDEADBEEF (slot 3, with TEMPLATE_BITS=0 during the write) → read slot 3 returns 0xC123…; re-read slot 0 still returns 0x0123….
- FF_WRITE with D0=0x0123FEEDDEADBEEF0123FEEDDEADBEEF, D1=0xC123FEEDDEADBEEF0123FEEDDEADBEEF → FF_READ with TEMPLATE_BITS=3 returns D0 on READ_DATA_0 and D1 on READ_DATA_1.
- Two INPUT_WRITEs of 0x0123FEEDDEADBEEF0123FEEDDEADBEEF then 0xFEEDDEADBEEFEEEEDDDDCCCCBBBBAAAA:
  - First INPUT_READ → 0x0123…, TEMPLATE_CHANGE=0.
  - Second INPUT_READ → 0xFEED…, TEMPLATE_CHANGE=1.
- FIFO boundaries: write INPUT_DEPTH+1 words → the extra word is dropped, and reads return words 0..INPUT_DEPTH-1 in order. A read on empty leaves READ_DATA_0 unchanged.
- Strobe handling:
  - TEMPLATE_WRITE and INPUT_READ in the same cycle → only the write executes.
  - A strobe while READY=0 is ignored.
  - RST low mid-read → READY=1 and outputs 0 immediately.
